// File: rtl/vga_pkg.sv
// Shared display-path definitions: RGB555 pixel type, unpacker states and
// frame geometry constants used by both the unpacker and the timing generator.
package vga_pkg;

   typedef logic [15:0] rgb555_t;

   typedef enum logic [1:0] {
      UNPACK_IDLE   = 2'd0,
      UNPACK_ACTIVE = 2'd1,
      UNPACK_DONE   = 2'd2
   } unpack_state_t;

   localparam rgb555_t     RGB555_MASK         = 16'h7FFF;
   localparam rgb555_t     VGA_UNDERFLOW_COLOR = 16'h7C1F;
   localparam int unsigned VGA_PIXELS_800X600  = 800 * 600;

endpackage

// File: rtl/vga_unpack_stats.sv
// Diagnostic counters for the pixel unpacker: saturating underrun count since
// reset and a sticky short/long-frame flag. Cleared only by vga_resetn.
module vga_unpack_stats (
   input  logic        VGA_CLK,
   input  logic        vga_resetn,
   input  logic        underrun,
   input  logic        frame_bad,
   output logic [15:0] underflow_count,
   output logic        frame_error
);

   always_ff @(posedge VGA_CLK or negedge vga_resetn) begin
      if (!vga_resetn) begin
         underflow_count <= 16'h0000;
         frame_error     <= 1'b0;
      end else begin
         if (underrun && (underflow_count != 16'hFFFF))
            underflow_count <= underflow_count + 16'd1;
         if (frame_bad)
            frame_error <= 1'b1;
      end
   end

endmodule

// File: rtl/vga_pixel_unpacker.sv
// Splits 32-bit framebuffer words from a show-ahead FIFO into RGB555 pixels,
// one per read_pixel request. Optional statistics: define VGA_UNPACK_STATS_EN.
module vga_pixel_unpacker
   import vga_pkg::*;
#(
   parameter int unsigned PIXELS_PER_FRAME = VGA_PIXELS_800X600,
   parameter logic [15:0] UNDERFLOW_COLOR  = VGA_UNDERFLOW_COLOR,
   parameter int unsigned CNT_W            = 20
) (
   input  logic        VGA_CLK,
   input  logic        vga_resetn,
   input  logic        frame_start,
   input  logic        read_pixel,
   output logic [15:0] pixel,
   input  logic [31:0] fifo_q,
   input  logic        fifo_empty,
   output logic        fifo_rdreq,
   output logic        underflow,
   output logic [15:0] underflow_count,
   output logic        frame_error
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXELS_PER_FRAME - 1);

   unpack_state_t    state;
   logic             sel;
   logic [CNT_W-1:0] pix_cnt;
   logic             serve;
   logic             underrun;
   rgb555_t          half;

   // frame_start pre-empts a coincident request so the new frame starts on a word boundary
   assign serve      = read_pixel & (state == UNPACK_ACTIVE) & !frame_start;
   assign underrun   = serve & fifo_empty;
   assign fifo_rdreq = serve & sel & !fifo_empty;
   assign half       = sel ? rgb555_t'(fifo_q[31:16]) : rgb555_t'(fifo_q[15:0]);

   // sel keeps toggling on underruns so a late word still lands in its screen slot
   always_ff @(posedge VGA_CLK or negedge vga_resetn) begin
      if (!vga_resetn) begin
         state     <= UNPACK_IDLE;
         sel       <= 1'b0;
         pix_cnt   <= '0;
         underflow <= 1'b0;
      end else if (frame_start) begin
         state     <= UNPACK_ACTIVE;
         sel       <= 1'b0;
         pix_cnt   <= '0;
         underflow <= 1'b0;
      end else if (serve) begin
         sel     <= ~sel;
         pix_cnt <= pix_cnt + CNT_W'(1);
         if (fifo_empty)
            underflow <= 1'b1;
         if (pix_cnt == CNT_LAST)
            state <= UNPACK_DONE;
      end
   end

   always_ff @(posedge VGA_CLK or negedge vga_resetn) begin
      if (!vga_resetn)
         pixel <= 16'h0000;
      else if (read_pixel) begin
         if (!serve)
            pixel <= 16'h0000;
         else if (fifo_empty)
            pixel <= UNDERFLOW_COLOR;
         else
            pixel <= half & RGB555_MASK;
      end
   end

`ifdef VGA_UNPACK_STATS_EN
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PIXELS_PER_FRAME);

   logic frame_bad;

   assign frame_bad = frame_start & (state == UNPACK_ACTIVE) & (pix_cnt != CNT_FULL);

   vga_unpack_stats u_stats (
      .VGA_CLK         (VGA_CLK),
      .vga_resetn      (vga_resetn),
      .underrun        (underrun),
      .frame_bad       (frame_bad),
      .underflow_count (underflow_count),
      .frame_error     (frame_error)
   );
`else
   assign underflow_count = 16'h0000;
   assign frame_error     = 1'b0;
`endif

endmodule

// File: tb/tb_vga_pixel_unpacker.sv
// Self-checking bench for vga_pixel_unpacker: directed steps plus a random
// phase, checked against a frame-position model with a queue-based FIFO.
module tb_vga_pixel_unpacker;

   localparam int          PPF = 64;
   localparam logic [15:0] UFC = 16'h7C1F;
`ifdef VGA_UNPACK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        VGA_CLK = 1'b0;
   logic        vga_resetn;
   logic        frame_start;
   logic        read_pixel;
   logic [15:0] pixel;
   logic [31:0] fifo_q;
   logic        fifo_empty;
   logic        fifo_rdreq;
   logic        underflow;
   logic [15:0] underflow_count;
   logic        frame_error;

   vga_pixel_unpacker #(.PIXELS_PER_FRAME(PPF)) dut (
      .VGA_CLK         (VGA_CLK),
      .vga_resetn      (vga_resetn),
      .frame_start     (frame_start),
      .read_pixel      (read_pixel),
      .pixel           (pixel),
      .fifo_q          (fifo_q),
      .fifo_empty      (fifo_empty),
      .fifo_rdreq      (fifo_rdreq),
      .underflow       (underflow),
      .underflow_count (underflow_count),
      .frame_error     (frame_error)
   );

   always #5 VGA_CLK = ~VGA_CLK;

   int          checks   = 0;
   int          failures = 0;
   int          pop_cnt  = 0;
   logic [31:0] fifo[$];

   // model: 0 idle, 1 active, 2 done; m_pos = pixels served this frame
   int          m_state = 0;
   int          m_pos   = 0;
   logic [15:0] m_pix   = 16'h0;
   bit          m_uf    = 1'b0;
   logic [15:0] m_ufc   = 16'h0;
   bit          m_ferr  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sync_fifo();
      fifo_empty = (fifo.size() == 0);
      fifo_q     = fifo_empty ? 32'hDEAD_BEEF : fifo[0];
   endtask

   task automatic model_reset();
      m_state = 0; m_pos = 0; m_pix = 16'h0; m_uf = 1'b0; m_ufc = 16'h0; m_ferr = 1'b0;
   endtask

   task automatic step(input bit rp, input bit fs, input string tag);
      bit          exp_pop;
      bit          dut_pop;
      logic [31:0] w;
      logic [15:0] h;
      exp_pop = 1'b0;
      @(negedge VGA_CLK);
      read_pixel  = rp;
      frame_start = fs;
      sync_fifo();
      if (fs) begin
         if (m_state == 1 && m_pos != PPF) m_ferr = 1'b1;
         m_state = 1; m_pos = 0; m_uf = 1'b0;
         if (rp) m_pix = 16'h0;
      end else if (rp) begin
         if (m_state != 1) m_pix = 16'h0;
         else begin
            if (fifo.size() == 0) begin
               m_pix = UFC;
               m_uf  = 1'b1;
               if (m_ufc != 16'hFFFF) m_ufc = m_ufc + 16'd1;
            end else begin
               w       = fifo[0];
               h       = (m_pos % 2 == 1) ? w[31:16] : w[15:0];
               m_pix   = {1'b0, h[14:0]};
               exp_pop = (m_pos % 2 == 1);
            end
            m_pos++;
            if (m_pos == PPF) m_state = 2;
         end
      end
      #1;
      chk({tag, "_rdreq"}, {31'd0, fifo_rdreq}, {31'd0, exp_pop});
      dut_pop = fifo_rdreq;
      @(posedge VGA_CLK);
      #1;
      read_pixel  = 1'b0;
      frame_start = 1'b0;
      if (dut_pop && fifo.size() > 0) begin
         void'(fifo.pop_front());
         pop_cnt++;
      end
      sync_fifo();
      chk({tag, "_pixel"}, {16'd0, pixel}, {16'd0, m_pix});
      chk({tag, "_uflag"}, {31'd0, underflow}, {31'd0, m_uf});
      chk({tag, "_ucount"}, {16'd0, underflow_count}, {16'd0, STATS ? m_ufc : 16'h0});
      chk({tag, "_ferr"}, {31'd0, frame_error}, {31'd0, STATS ? m_ferr : 1'b0});
   endtask

   initial begin
      logic [31:0] w;
      bit          rp;
      bit          fs;

      vga_resetn  = 1'b0;
      read_pixel  = 1'b0;
      frame_start = 1'b0;
      sync_fifo();
      repeat (2) @(negedge VGA_CLK);
      #1;
      chk("rst_pixel", {16'd0, pixel}, 32'd0);
      chk("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
      chk("rst_uflag", {31'd0, underflow}, 32'd0);
      chk("rst_ucount", {16'd0, underflow_count}, 32'd0);
      chk("rst_ferr", {31'd0, frame_error}, 32'd0);
      @(negedge VGA_CLK);
      vga_resetn = 1'b1;

      // idle request: no pop, pixel 0
      fifo.push_back(32'hBBBB_2AAA);
      step(1, 0, "idle_req");
      step(0, 1, "fs0");
      pop_cnt = 0;
      step(1, 0, "tp1a");
      chk("tp1_px0", {16'd0, pixel}, 32'h0000_2AAA);
      chk("tp1_pops0", pop_cnt, 0);
      step(1, 0, "tp1b");
      chk("tp1_px1", {16'd0, pixel}, 32'h0000_3BBB);
      chk("tp1_pops1", pop_cnt, 1);

      // underrun then late word
      step(1, 0, "tp2a");
      chk("tp2_px0", {16'd0, pixel}, 32'h0000_7C1F);
      chk("tp2_uflag", {31'd0, underflow}, 32'd1);
      fifo.push_back(32'h1234_5678);
      step(1, 0, "tp2b");
      chk("tp2_px1", {16'd0, pixel}, 32'h0000_1234);
      chk("tp2_pops", pop_cnt, 2);
      chk("tp2_ucount", {16'd0, underflow_count}, STATS ? 32'd1 : 32'd0);

      // reset mid-frame with sel=1
      fifo.push_back(32'hCAFE_F00D);
      step(1, 0, "pre_rst");
      @(negedge VGA_CLK);
      read_pixel = 1'b1;
      sync_fifo();
      #1;
      chk("pre_rst_rdreq", {31'd0, fifo_rdreq}, 32'd1);
      #1;
      vga_resetn = 1'b0;
      #1;
      chk("mid_rst_pixel", {16'd0, pixel}, 32'd0);
      chk("mid_rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
      chk("mid_rst_uflag", {31'd0, underflow}, 32'd0);
      chk("mid_rst_ucount", {16'd0, underflow_count}, 32'd0);
      chk("mid_rst_ferr", {31'd0, frame_error}, 32'd0);
      model_reset();
      read_pixel = 1'b0;
      @(negedge VGA_CLK);
      vga_resetn = 1'b1;
      step(1, 0, "post_rst_a");
      step(1, 0, "post_rst_b");
      fifo.delete();

      // full frame, continuous requests
      for (int i = 0; i < PPF / 2; i++) fifo.push_back($urandom);
      step(0, 1, "fs_full");
      pop_cnt = 0;
      for (int i = 0; i < PPF; i++) step(1, 0, "full");
      chk("full_pops", pop_cnt, PPF / 2);
      chk("full_uflag", {31'd0, underflow}, 32'd0);
      fifo.push_back(32'h5555_AAAA);
      step(1, 0, "done_extra");
      chk("done_px", {16'd0, pixel}, 32'd0);
      chk("done_pops", pop_cnt, PPF / 2);
      step(0, 1, "fs_after_full");
      chk("after_full_ferr", {31'd0, frame_error}, 32'd0);
      fifo.delete();

      // short frame with underruns
      for (int i = 0; i < 3; i++) fifo.push_back($urandom);
      for (int i = 0; i < 10; i++) step(1, 0, "short");
      chk("short_uflag", {31'd0, underflow}, 32'd1);
      step(0, 1, "fs_short");
      chk("short_ferr", {31'd0, frame_error}, STATS ? 32'd1 : 32'd0);
      chk("short_uflag_clr", {31'd0, underflow}, 32'd0);

      // frame_start with coincident request
      w = 32'h6789_4321;
      fifo.push_back(w);
      step(1, 1, "fs_rp");
      chk("fs_rp_px", {16'd0, pixel}, 32'd0);
      step(1, 0, "fs_rp_next");
      chk("fs_rp_low", {16'd0, pixel}, 32'h0000_4321);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 4) fifo.push_back($urandom);
         fs = ($urandom_range(0, 79) == 0);
         rp = ($urandom_range(0, 3) != 0);
         step(rp, fs, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
